// File: rtl/fu_issue_ctrl.sv
// Issue stage for the 8-bit functional unit.
// It queues command words in a small FIFO and owns the A/B/C operand registers.
// Each command runs IDLE -> EXEC -> WB: the FU result is sampled at the end of
// EXEC, then written back in WB and shown downstream as a one-cycle pulse.
module fu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    input  logic        ld_en,
    input  logic [1:0]  ld_sel,
    input  logic [7:0]  ld_data,
    output logic [7:0]  fu_instruction,
    output logic [2:0]  fu_select,
    output logic [7:0]  fu_a,
    output logic [7:0]  fu_b,
    output logic [7:0]  fu_c,
    input  logic [7:0]  fu_f,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t           state_q, state_d;
    logic [12:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       instr_q, instr_d;
    logic [2:0]       sel_q, sel_d;
    logic [1:0]       dest_q, dest_d;
    logic [7:0]       result_q, result_d;
    logic [7:0]       a_q, a_d, b_q, b_d, c_q, c_d;

    logic        full, empty, push, pop;
    logic [12:0] head;
    logic        unused_rsvd;

    // The low three command bits are reserved; they are never stored or used.
    assign unused_rsvd = ^cmd_data[2:0];

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign head      = fifo_q[rd_ptr_q];

    assign busy           = (state_q != IDLE) || !empty;
    assign fu_instruction = instr_q;
    assign fu_select      = sel_q;
    assign fu_a           = a_q;
    assign fu_b           = b_q;
    assign fu_c           = c_q;
    assign res_valid      = (state_q == WB);
    assign res_data       = result_q;

    // FIFO storage: keep only instruction, select and dest (bits [15:3]).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_data[15:3];
        end
    end

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // Sequencer next state: pop into the current command, sample FU, write back.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        sel_d    = sel_q;
        dest_d   = dest_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    instr_d = head[12:5];
                    sel_d   = head[4:2];
                    dest_d  = head[1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = fu_f;
                state_d  = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers: write-back has priority; the load port only acts when idle.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (state_q == WB) begin
            case (dest_q)
                2'd0:    a_d = result_q;
                2'd1:    b_d = result_q;
                2'd2:    c_d = result_q;
                default: ;
            endcase
        end else if (ld_en && !busy) begin
            case (ld_sel)
                2'd0:    a_d = ld_data;
                2'd1:    b_d = ld_data;
                2'd2:    c_d = ld_data;
                default: ;
            endcase
        end
    end

    // State, pointers and operand/result registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= '0;
            sel_q    <= '0;
            dest_q   <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            sel_q    <= sel_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
        end
    end

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Bench for fu_issue_ctrl: a small FU model drives fu_f, a stimulus process
// issues commands and queues expected results, and a monitor checks each pulse.
module tb_fu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        ld_en;
    logic [1:0]  ld_sel;
    logic [7:0]  ld_data;
    logic [7:0]  fu_instruction;
    logic [2:0]  fu_select;
    logic [7:0]  fu_a, fu_b, fu_c;
    logic [7:0]  fu_f;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    fu_issue_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
        .fu_instruction(fu_instruction), .fu_select(fu_select),
        .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c), .fu_f(fu_f),
        .res_valid(res_valid), .res_data(res_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FU model: select picks the operand pair, lowest set instruction bit wins.
    logic [7:0] fx, fy;
    always_comb begin
        fx = fu_b;
        fy = fu_c;
        fu_f = 8'h00;
        if (fu_select == 3'b110) begin
            fx = fu_a;
            fy = fu_b;
        end else if (fu_select == 3'b101) begin
            fx = fu_a;
            fy = fu_c;
        end
        if (fu_instruction[0])      fu_f = fx + fy;
        else if (fu_instruction[1]) fu_f = fx - fy;
        else if (fu_instruction[2]) fu_f = fx & fy;
        else if (fu_instruction[3]) fu_f = fx | fy;
        else if (fu_instruction[4]) fu_f = fx ^ fy;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL res_unexpected: got=%h expected=no pulse", res_data);
            end else begin
                chk("res_data", {8'h00, res_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] d);
        ld_en = 1'b1;
        ld_sel = sel;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic push_cmd(input logic [15:0] w, input logic [7:0] e, output int waits);
        waits = 0;
        cmd_valid = 1'b1;
        cmd_data = w;
        while (!cmd_ready && waits < 50) begin
            tick();
            waits++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got=cmd_ready 0 expected=cmd_ready 1");
        end else begin
            exp_q.push_back(e);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got=busy 1 expected=busy 0");
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = '0;
        ld_en = 1'b0;
        ld_sel = '0;
        ld_data = '0;

        // Reset state
        tick();
        tick();
        chk("rst_a", {8'h00, fu_a}, 16'h0000);
        chk("rst_b", {8'h00, fu_b}, 16'h0000);
        chk("rst_c", {8'h00, fu_c}, 16'h0000);
        chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_instr", {8'h00, fu_instruction}, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Basic add into C, with latency checks
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        load(2'd2, 8'h09);
        chk("ld_a", {8'h00, fu_a}, 16'h0005);
        push_cmd(16'h01D0, 8'h08, w);
        chk("lat_t0_valid", {15'd0, res_valid}, 16'd0);
        chk("lat_t0_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("lat_t1_valid", {15'd0, res_valid}, 16'd0);
        chk("exec_instr", {8'h00, fu_instruction}, 16'h0001);
        chk("exec_select", {13'd0, fu_select}, 16'd6);
        tick();
        chk("lat_t2_valid", {15'd0, res_valid}, 16'd1);
        chk("lat_t2_data", {8'h00, res_data}, 16'h0008);
        tick();
        chk("lat_t3_valid", {15'd0, res_valid}, 16'd0);
        chk("add_c", {8'h00, fu_c}, 16'h0008);
        chk("hold_res_data", {8'h00, res_data}, 16'h0008);

        // Dependent chain: OR into A, then AND of new A with B, discarded
        load(2'd0, 8'h0C);
        load(2'd1, 8'h03);
        push_cmd(16'h08C0, 8'h0F, w);
        push_cmd(16'h04D8, 8'h03, w);
        wait_idle();
        chk("chain_a", {8'h00, fu_a}, 16'h000F);
        chk("chain_b", {8'h00, fu_b}, 16'h0003);
        chk("chain_c", {8'h00, fu_c}, 16'h0008);

        // FIFO fill: A=0F B=03 C=08, all dest=3
        push_cmd(16'h01D8, 8'h12, w);
        push_cmd(16'h02D8, 8'h0C, w);
        push_cmd(16'h04B8, 8'h08, w);
        push_cmd(16'h08B8, 8'h0F, w);
        push_cmd(16'h1078, 8'h0B, w);
        push_cmd(16'h0278, 8'hFB, w);
        chk("full_ready", {15'd0, cmd_ready}, 16'd0);
        push_cmd(16'h03BF, 8'h17, w);
        chk("full_waits", w[15:0], 16'd2);
        wait_idle();
        chk("full_a", {8'h00, fu_a}, 16'h000F);
        chk("last_instr_hold", {8'h00, fu_instruction}, 16'h0003);
        chk("last_select_hold", {13'd0, fu_select}, 16'd5);
        chk("all_results_seen", exp_q.size(), 16'd0);

        // Load ignored while busy; instruction 0x00 passes through
        push_cmd(16'h00D8, 8'h00, w);
        load(2'd0, 8'hFF);
        chk("busy_load_a", {8'h00, fu_a}, 16'h000F);
        wait_idle();
        load(2'd0, 8'hFF);
        chk("idle_load_a", {8'h00, fu_a}, 16'h00FF);
        load(2'd3, 8'h55);
        chk("sel3_a", {8'h00, fu_a}, 16'h00FF);
        chk("sel3_b", {8'h00, fu_b}, 16'h0003);
        chk("sel3_c", {8'h00, fu_c}, 16'h0008);

        // Reset while in EXEC with two entries queued
        push_cmd(16'h01D8, 8'h02, w);
        push_cmd(16'h02D8, 8'hFC, w);
        push_cmd(16'h04D8, 8'h03, w);
        push_cmd(16'h08D8, 8'hFF, w);
        tick();
        chk("midrst_exec_instr", {8'h00, fu_instruction}, 16'h0002);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_a", {8'h00, fu_a}, 16'h0000);
        chk("midrst_b", {8'h00, fu_b}, 16'h0000);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_ready", {15'd0, cmd_ready}, 16'd1);
        chk("midrst_instr", {8'h00, fu_instruction}, 16'h0000);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", {15'd0, busy}, 16'd0);
        load(2'd0, 8'h07);
        load(2'd1, 8'h02);
        push_cmd(16'h02D0, 8'h05, w);
        wait_idle();
        chk("post_rst_c", {8'h00, fu_c}, 16'h0005);
        chk("post_rst_results", exp_q.size(), 16'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
